// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - message-granular round-robin arbiter in front of one UART tx byte channel
// Optional lock watchdog compiled in with UART_TX_ARB_WDOG_EN.
module uart_tx_arb #(
  parameter int N           = 4,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_data,
  output logic           tx_new_data,
  input  logic           tx_busy,
  output logic           arb_busy,
  output logic           lock_err
);

  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {ARB, FETCH, SEND, WAITB, WAITD} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    grant_nx;
  logic [PW-1:0]   rr_ptr, rr_ptr_nx, win;
  logic [7:0]      tx_data_nx;
  logic            last_r, last_nx;
  logic            any_valid;
  logic            own_valid;
  logic            wdog_fire;

  // While locked rr_ptr is the owner index, so it doubles as the data mux select.
  assign own_valid = |(grant & req_valid);

  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && req_valid[(int'(rr_ptr) + 1 + k) % N]) begin
        any_valid = 1'b1;
        win       = PW'((int'(rr_ptr) + 1 + k) % N);
      end
    end
  end

`ifdef UART_TX_ARB_WDOG_EN
  logic [15:0] wdog_cnt;

  assign wdog_fire = (state == FETCH) && !own_valid &&
                     ((32'(wdog_cnt) + 32'd1) >= 32'(WDOG_CYCLES));

  // Held at zero outside FETCH, which clears it on every entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wdog_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= wdog_fire;
      if (state != FETCH)
        wdog_cnt <= '0;
      else if (!own_valid && wdog_cnt != 16'hFFFF)
        wdog_cnt <= wdog_cnt + 16'd1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
  assign lock_err    = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    rr_ptr_nx  = rr_ptr;
    tx_data_nx = tx_data;
    last_nx    = last_r;
    case (state)
      ARB: begin
        if (any_valid) begin
          grant_nx  = {{(N-1){1'b0}}, 1'b1} << win;
          rr_ptr_nx = win;
          state_nx  = FETCH;
        end
      end
      FETCH: begin
        if (own_valid) begin
          tx_data_nx = req_data[int'(rr_ptr)*8 +: 8];
          last_nx    = req_last[rr_ptr];
          state_nx   = SEND;
        end else if (wdog_fire) begin
          grant_nx = '0;
          state_nx = ARB;
        end
      end
      SEND:  state_nx = WAITB;
      WAITB: if (tx_busy) state_nx = WAITD;
      WAITD: begin
        if (!tx_busy) begin
          if (last_r) begin
            grant_nx = '0;
            state_nx = ARB;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ARB;
      grant   <= '0;
      rr_ptr  <= PW'(N - 1);
      tx_data <= '0;
      last_r  <= 1'b0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      rr_ptr  <= rr_ptr_nx;
      tx_data <= tx_data_nx;
      last_r  <= last_nx;
    end
  end

  // Gated by reset so nothing is accepted or strobed in a reset cycle.
  assign req_ready   = (reset && state == FETCH) ? (grant & req_valid) : '0;
  assign tx_new_data = reset && (state == SEND);
  assign arb_busy    = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed bench for uart_tx_arb with requester queues and a busy-holding tx model
module tb_uart_tx_arb;
  localparam int N        = 4;
  localparam int BUSY_LEN = 20;

  logic           clock = 1'b0;
  logic           reset;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [7:0]     tx_data;
  logic           tx_new_data, tx_busy, arb_busy, lock_err;

  always #5 clock = ~clock;

  uart_tx_arb #(.N(N), .WDOG_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .lock_err(lock_err)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mdat [N][16];
  logic       mlast[N][16];
  int         head[N] = '{default: 0};
  int         tail[N] = '{default: 0};
  logic       hold = 1'b0;

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mdat[i][tail[i]]  = d;
    mlast[i][tail[i]] = l;
    tail[i]++;
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  logic [11:0] log_q[$];
  int   busy_cnt = 0, cyc = 0, fall_cyc = 0, rdy1_gap = -1;
  int   stray = 0, double_pulse = 0, lock_cnt = 0, lock_gap = -1;
  logic start_pend = 1'b0, prev_new = 1'b0, prev_rdy1 = 1'b0;
  logic [N-1:0] rdy_prev = '0, lock_grant = '1;

  // Requester queues and the transmitter: busy rises one cycle after the strobe, holds BUSY_LEN cycles.
  initial begin
    logic [N-1:0]   v, l;
    logic [8*N-1:0] d;
    tx_busy = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        busy_cnt = 0; start_pend = 1'b0; tx_busy = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin tx_busy = 1'b0; fall_cyc = cyc; end
        end
        if (start_pend) begin start_pend = 1'b0; tx_busy = 1'b1; busy_cnt = BUSY_LEN; end
      end
      for (int i = 0; i < N; i++) if (rdy_prev[i]) head[i]++;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
        if (hold) begin
          v[i] = 1'b1; l[i] = 1'b1;
        end else if (head[i] != tail[i]) begin
          v[i] = 1'b1; l[i] = mlast[i][head[i]]; d[8*i +: 8] = mdat[i][head[i]];
        end
      end
      req_valid = v; req_last = l; req_data = d;
      #1;
      rdy_prev = req_ready;
      if (((req_ready & ~grant) != 0) || ($countones(req_ready) > 1)) stray++;
      if (tx_new_data) begin
        log_q.push_back({grant, tx_data});
        start_pend = 1'b1;
        if (prev_new) double_pulse++;
      end
      prev_new = tx_new_data;
      if (req_ready[1] && !prev_rdy1) rdy1_gap = cyc - fall_cyc;
      prev_rdy1 = req_ready[1];
      if (lock_err) begin lock_cnt++; lock_gap = cyc - fall_cyc; lock_grant = grant; end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (n < 3000 && (pending() || arb_busy || tx_busy || start_pend)) begin
      @(negedge clock); #2; n++;
    end
    check({tag, "_drain_timeout"}, 32'(n >= 3000), 32'd0);
  endtask

  task automatic check_log(input string tag, input int base, input int idx, input logic [11:0] exp);
    logic [11:0] got = 12'hFFF;
    if (base + idx < log_q.size()) got = log_q[base + idx];
    check($sformatf("%s_%0d", tag, idx), 32'(got), 32'(exp));
  endtask

  logic [11:0] rr_exp[5]   = '{12'h100, 12'h201, 12'h402, 12'h803, 12'h100};
  logic [11:0] lock_exp[4] = '{12'h1A0, 12'h1A1, 12'h1A2, 12'h2B0};
  logic [11:0] rst_exp[4]  = '{12'h1C0, 12'h1C1, 12'h1C2, 12'h2D0};

  initial begin
    int base, n;
    reset = 1'b0; hold = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_new_data", 32'(tx_new_data), 32'h0);
    check("reset_arb_busy", 32'(arb_busy), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_lock_err", 32'(lock_err), 32'h0);
    hold = 1'b0;
    @(negedge clock); reset = 1'b1;

    base = log_q.size();
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b1);
    drain("single");
    check("single_count", 32'(log_q.size() - base), 32'd2);
    check_log("single", base, 0, 12'h441);
    check_log("single", base, 1, 12'h442);
    check("single_grant_after", 32'(grant), 32'h0);

    reset = 1'b0; @(negedge clock); reset = 1'b1;
    base = log_q.size();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 8'(i), 1'b1);
    drain("rr");
    check("rr_count", 32'(log_q.size() - base), 32'd8);
    for (int k = 0; k < 5; k++) check_log("rr", base, k, rr_exp[k]);

    base = log_q.size();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1); push(1, 8'hB0, 1'b1);
    drain("lock");
    check("lock_count", 32'(log_q.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) check_log("lock", base, k, lock_exp[k]);
    check("lock_ready1_gap", 32'(rdy1_gap), 32'd2);

    base = log_q.size();
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1); push(1, 8'hD0, 1'b1);
    n = 0;
    while (n < 200 && !tx_busy) begin @(negedge clock); #2; n++; end
    check("midrst_busy_timeout", 32'(n >= 200), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #2;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_arb_busy", 32'(arb_busy), 32'h0);
    reset = 1'b1;
    drain("midrst");
    check("midrst_count", 32'(log_q.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) check_log("midrst", base, k, rst_exp[k]);

`ifdef UART_TX_ARB_WDOG_EN
    base = log_q.size();
    push(3, 8'hE0, 1'b0); push(0, 8'hF0, 1'b1);
    drain("wdog");
    check("wdog_pulses", 32'(lock_cnt), 32'd1);
    check("wdog_gap", 32'(lock_gap), 32'd17);
    check("wdog_grant", 32'(lock_grant), 32'h0);
    check_log("wdog", base, 0, 12'h8E0);
    check_log("wdog", base, 1, 12'h1F0);
`else
    check("no_wdog_lock_err", 32'(lock_cnt), 32'd0);
`endif

    check("stray_ready", 32'(stray), 32'd0);
    check("double_pulse", 32'(double_pulse), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
